// File: rtl/sram_access_controller.sv
// sram_access_controller: serves 32-bit MEM-stage loads/stores as two half-word accesses on a 16-bit SRAM.
module sram_access_controller #(
    parameter int SRAM_WAIT = 2,
    parameter int ADDR_BASE = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memReadEn,
    input  logic        memWriteEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic [17:0] sram_addr,
    input  logic [15:0] sram_dq_in,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
    localparam logic [3:0] LAST = 4'(SRAM_WAIT - 1);
    state_t      state;
    logic [3:0]  cnt;
    logic        op_write;
    logic [16:0] word_q;
    logic [16:0] word;
    logic        req;
    logic        last;
    logic        busy;
    assign req  = memReadEn | memWriteEn;
    assign word = 17'((address - 32'(ADDR_BASE)) >> 2);
    assign last = cnt == LAST;
    assign busy = state == LOW || state == HIGH;
    // ready drops in the same cycle a request appears so the pipeline freezes at once
    assign ready = ~req | (state == DONE);
    always_comb begin
        sram_addr   = {word_q, state == HIGH};
        sram_we_n   = ~(busy & op_write);
        sram_dq_oe  = busy & op_write;
        sram_dq_out = !op_write ? 16'h0 : state == LOW ? writeData[15:0] : state == HIGH ? writeData[31:16] : 16'h0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            op_write <= 1'b0;
            word_q   <= 17'd0;
            readData <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op_write <= memWriteEn;
                    word_q   <= word;
                    cnt      <= 4'd0;
                    state    <= LOW;
                end
                LOW: if (last) begin
                    cnt   <= 4'd0;
                    state <= HIGH;
                    if (!op_write) readData[15:0] <= sram_dq_in;
                end else cnt <= cnt + 4'd1;
                HIGH: if (last) begin
                    cnt   <= 4'd0;
                    state <= DONE;
                    if (!op_write) readData[31:16] <= sram_dq_in;
                end else cnt <= cnt + 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sram_access_controller.md
Name: sram_access_controller

Overview:
- Memory-stage responder for the pipeline's memory commands: consumes `memReadEn`/`memWriteEn` from the MEM stage and performs the 32-bit word access on an external 16-bit SRAM.
- Each word is two half-word accesses (low, then high), with a programmable wait per half.
- Deasserts `ready` combinationally while a request is outstanding, so the pipeline freezes until the word completes.

Parameters:
- SRAM_WAIT, 2, cycles spent on each half-word access; legal range 1..15.
- ADDR_BASE, 1024, byte address mapped to SRAM word 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- memReadEn  in  1  load request; held stable by the frozen pipeline until `ready`.
- memWriteEn  in  1  store request; held stable until `ready`.
- address  in  32  byte address from the ALU result.
- writeData  in  32  store data.
- readData  out  32  loaded word; registered.
- ready  out  1  high when no request is pending, or when the access completes.
- sram_addr  out  18  SRAM half-word address.
- sram_dq_in  in  16  SRAM read data.
- sram_dq_out  out  16  SRAM write data.
- sram_dq_oe  out  1  drive enable for the DQ bus.
- sram_we_n  out  1  SRAM write strobe, active low.

Behaviour:
- Word address: wordAddr = (address - ADDR_BASE) >> 2, mod 2^32, truncated to 17 bits.
  - address[1:0] ignored.
  - Out-of-range addresses alias; no error.
- sram_addr = {wordAddr, half}; half = 1 only in state HIGH.
- FSM states: IDLE, LOW, HIGH, DONE. 4-bit wait counter `cnt`.
  - IDLE: if (memReadEn | memWriteEn), latch op (write wins if both asserted; readData then not updated), go to LOW, cnt=0. Else stay.
  - LOW: cnt increments each cycle. When cnt == SRAM_WAIT-1: capture sram_dq_in into readData[15:0] (reads only), go to HIGH, cnt=0.
  - HIGH: same counting. On the last cycle: capture sram_dq_in into readData[31:16] (reads only), go to DONE.
  - DONE: one cycle, then unconditionally to IDLE.
- ready = ~(memReadEn | memWriteEn) | (state == DONE). Combinational, so it is low in the same cycle a request first appears.
- Latency: request first seen at cycle 0 → ready = 1 at cycle 2*SRAM_WAIT+1.
  - That is 2*SRAM_WAIT+1 frozen cycles.
  - The full readData is valid in the DONE cycle.
- Back-to-back requests:
  - The pipeline advances on the DONE edge.
  - The next request is seen in IDLE the following cycle, with ready = 0 immediately.
  - One idle cycle between accesses.
- Write path, decoded from state and the latched op:
  - sram_we_n = 0 and sram_dq_oe = 1 throughout LOW and HIGH when the op is a write; otherwise sram_we_n = 1 and sram_dq_oe = 0.
  - sram_dq_out = writeData[15:0] in LOW, writeData[31:16] in HIGH, 0 otherwise.
- Read path: sram_dq_oe = 0 and sram_we_n = 1 in all states.
- readData holds its value between reads; writes never alter it.
- Reset (any state, including mid-access):
  - state = IDLE, cnt = 0, readData = 0.
  - sram_we_n = 1, sram_dq_oe = 0, sram_dq_out = 0, sram_addr = 0.
  - ready follows the request inputs.
  - An interrupted access is abandoned, not resumed.
- Requests dropped while not in IDLE (illegal): the FSM still completes the access; ready = 1 when the inputs are low.

Test Plan:
- Idle: rst, then no request for 10 cycles → ready = 1 constantly, sram_we_n = 1, sram_dq_oe = 0, readData = 0.
- Write, SRAM_WAIT=2: address=1028, writeData=0xDEADBEEF → sram_addr = 2 with dq_out = 0xBEEF for 2 cycles, then sram_addr = 3 with dq_out = 0xDEAD for 2 cycles; we_n low for 4 cycles; ready rises at cycle 5.
- Read after write, with an SRAM model: read address=1028 → readData = 0xDEADBEEF in the DONE cycle; ready is low for exactly 5 cycles.
- Back-to-back: store to 1024, then load from 1024 → one IDLE gap between accesses; second ready at cycle 11; readData matches the stored value.
- Reset mid-access: assert rst in the second HIGH cycle of a write → next cycle state IDLE, we_n = 1, dq_oe = 0, readData = 0; a new request then starts a full-length access.
- Both enables asserted, and SRAM_WAIT=1: write is performed and readData is unchanged; with SRAM_WAIT=1 the access takes 3 cycles to ready.
